input_port_conditioner: RTL and testbench
=========================================

// Module: input_port_conditioner
// PURPOSE
//  Front-end for the CPU input port. Sits directly upstream of the CPU and drives its in_port and ready_in.
//  Synchronises and debounces the raw "ready" push-button, and synchronises the raw switch bus.
//  Snapshots the switches on each confirmed press, so the CPU sees a clean, stable word.
//  The CPU's wait-for-ready / wait-for-pattern instructions then see exactly one clean rising edge per press.
// PARAMETERS
//  BUS_WIDTH        8  width of switch bus and in_port
//  SYNC_STAGES      2  flops in each synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  4  consecutive stable synchronised cycles needed to accept a level change (>=1)
// PORTS
//  clk        in   1          system clock, all state on posedge
//  reset      in   1          asynchronous, active-high reset
//  sw_raw     in   BUS_WIDTH  raw switch levels, asynchronous to clk
//  btn_raw    in   1          raw ready push-button, asynchronous, 1 = pressed, bouncy
//  in_port    out  BUS_WIDTH  switch snapshot taken at the last confirmed press
//  ready_in   out  1          debounced button level, registered
// BEHAVIOUR
//  Reset (async assert, sync release): all sync flops 0, state RELEASED, counter 0, in_port 0, ready_in 0.
//  Reset mid-operation: reset wins immediately. No pending press survives reset.
//  Synchronisers: btn_raw and each sw_raw bit pass through SYNC_STAGES flops, giving btn_s and sw_s.
//  Counter: width $clog2(DEBOUNCE_CYCLES+1), saturating never needed, cleared on every state change.
//  FSM (state held in the shared enum):
//   RELEASED:     btn_s=1 -> PRESS_WAIT, cnt<=0. Otherwise stay.
//   PRESS_WAIT:   btn_s=0 -> RELEASED, cnt<=0 (bounce rejected).
//                 btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; same edge in_port<=sw_s, ready_in<=1.
//                 Otherwise cnt++.
//   PRESSED:      btn_s=0 -> RELEASE_WAIT, cnt<=0. Otherwise stay.
//   RELEASE_WAIT: btn_s=1 -> PRESSED, cnt<=0 (bounce rejected, ready_in stays 1).
//                 btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED; same edge ready_in<=0.
//                 Otherwise cnt++.
//  ready_in is 1 exactly in PRESSED and RELEASE_WAIT, and is driven from a flop (no comb path to outputs).
//  Latency: count the first clk edge sampling btn_raw=1 as edge 1.
//   With btn_raw held stable, ready_in rises after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
//   Release is symmetric: ready_in falls after the same number of edges.
//  in_port changes only on the RELEASED/PRESS_WAIT -> PRESSED edge, and is held otherwise.
//   Switch movement while pressed or released is ignored until the next confirmed press.
//  Simultaneous switch change and press acceptance: the snapshot is the sw_s value at the accepting edge.
//  Minimum ready_in high time is DEBOUNCE_CYCLES+1 cycles, so the CPU's edge detector always sees it.
//  Held button: exactly one rising edge of ready_in, no retrigger.
// STRUCTURE
//  Package cpu_io_pkg holds:
//   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
//   default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
//  Sub-module bit_synchronizer #(WIDTH, STAGES), with async active-high reset.
//   Instanced once for btn_raw (WIDTH=1) and once for sw_raw (WIDTH=BUS_WIDTH).
//  FSM, counter and snapshot register live in this module.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1 Clean press: sw_raw=8'hA5, btn_raw 0->1 held -> ready_in=1 after edge 7, in_port=8'hA5.
//    Release held -> ready_in=0 after 7 edges.
//  2 Bounce: btn_raw toggles 1,0,1,0 per cycle, then held 1 -> no ready_in pulse during toggling.
//    ready_in rises 7 edges after the final 0->1.
//  3 Release bounce: while PRESSED, btn_raw low for 2 cycles then high -> ready_in stays 1, in_port unchanged.
//  4 Snapshot hold: after press with sw 8'h3C, change sw_raw to 8'hFF while held and after release -> in_port=8'h3C.
//    Next press -> in_port=8'hFF.
//  5 Reset mid-debounce: assert reset during PRESS_WAIT -> ready_in=0, in_port=0 immediately.
//    After release with btn held, a full 7-edge latency again.
//  6 Integration: drive CPU.in_port/ready_in from this block, program a wait-ready/load sequence.
//    One press -> CPU loads sw value exactly once, PC advances once.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared types and defaults for the CPU input-port front-end.
package cpu_io_pkg;

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;

  localparam int unsigned DEFAULT_BUS_WIDTH       = 8;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

  // The CPU sees the button as asserted from acceptance until the release is confirmed.
  function automatic logic is_asserted(btn_state_t s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/input_port_conditioner_if.sv
// Raw switch/button inputs and the conditioned word/ready pair handed to the CPU.
interface input_port_conditioner_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] sw_raw;
  logic                 btn_raw;
  logic [BUS_WIDTH-1:0] in_port;
  logic                 ready_in;

  modport master (output sw_raw, output btn_raw, input in_port, input ready_in);
  modport slave  (input sw_raw, input btn_raw, output in_port, output ready_in);
endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser chain for signals asynchronous to clk.
module bit_synchronizer #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/input_port_conditioner.sv
// Synchronises and debounces the ready button and snapshots the switch bus on each confirmed press.
module input_port_conditioner
  import cpu_io_pkg::*;
#(
  parameter int unsigned BUS_WIDTH       = DEFAULT_BUS_WIDTH,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic                     clk,
  input logic                     reset,
  input_port_conditioner_if.slave io
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 btn_s;
  logic [BUS_WIDTH-1:0] sw_s;

  bit_synchronizer #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (io.btn_raw),
    .q     (btn_s)
  );

  bit_synchronizer #(
    .WIDTH  (BUS_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (io.sw_raw),
    .q     (sw_s)
  );

  btn_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] in_port_q, in_port_d;
  logic                 ready_q, ready_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      in_port_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_port_q <= in_port_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_port_d = in_port_q;
    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Snapshot on the accepting edge so the CPU reads the word that matches this press.
          state_d   = PRESSED;
          cnt_d     = '0;
          in_port_d = sw_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    ready_d = is_asserted(state_d);
  end

  assign io.in_port  = in_port_q;
  assign io.ready_in = ready_q;

endmodule

// File: tb/tb_input_port_conditioner.sv
// Directed bench for input_port_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (7-edge latency).
module tb_input_port_conditioner;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  input_port_conditioner_if #(.BUS_WIDTH(8)) bus ();

  input_port_conditioner #(
    .BUS_WIDTH       (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal CPU stand-in: wait-for-ready, then load the port word and advance the PC once.
  logic       cpu_rdy_prev;
  logic [7:0] cpu_acc;
  int         cpu_loads;
  int         cpu_pc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdy_prev <= 1'b0;
      cpu_acc      <= 8'h00;
      cpu_loads    <= 0;
      cpu_pc       <= 0;
    end else begin
      cpu_rdy_prev <= bus.ready_in;
      if (bus.ready_in && !cpu_rdy_prev) begin
        cpu_acc   <= bus.in_port;
        cpu_loads <= cpu_loads + 1;
        cpu_pc    <= cpu_pc + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.btn_raw = 1'b0;
    bus.sw_raw  = 8'h00;
    repeat (3) step();
    vectors++;
    if (bus.ready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0", bus.ready_in);
    end
    vectors++;
    if (bus.in_port !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_in_port: got %h want 00", bus.in_port);
    end
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_clean_press();
    logic exp;
    bus.sw_raw  = 8'hA5;
    bus.btn_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 7);
      vectors++;
      if (bus.ready_in !== exp) begin
        miscompares++;
        $display("FAIL press_latency edge %0d: ready_in got %b want %b", i, bus.ready_in, exp);
      end
    end
    vectors++;
    if (bus.in_port !== 8'hA5) begin
      miscompares++;
      $display("FAIL press_snapshot: got %h want a5", bus.in_port);
    end
    bus.btn_raw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i < 7);
      vectors++;
      if (bus.ready_in !== exp) begin
        miscompares++;
        $display("FAIL release_latency edge %0d: ready_in got %b want %b", i, bus.ready_in, exp);
      end
    end
    repeat (2) step();
  endtask

  task automatic test_bounce();
    logic exp;
    logic [3:0] pattern;
    pattern    = 4'b0101;
    bus.sw_raw = 8'h96;
    for (int i = 0; i < 4; i++) begin
      bus.btn_raw = pattern[i];
      step();
      vectors++;
      if (bus.ready_in !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_reject step %0d: ready_in got %b want 0", i, bus.ready_in);
      end
    end
    bus.btn_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 7);
      vectors++;
      if (bus.ready_in !== exp) begin
        miscompares++;
        $display("FAIL bounce_latency edge %0d: ready_in got %b want %b", i, bus.ready_in, exp);
      end
    end
    vectors++;
    if (bus.in_port !== 8'h96) begin
      miscompares++;
      $display("FAIL bounce_snapshot: got %h want 96", bus.in_port);
    end
  endtask

  task automatic test_release_bounce();
    bus.sw_raw  = 8'h11;
    bus.btn_raw = 1'b0;
    repeat (2) step();
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (bus.ready_in !== 1'b1) begin
        miscompares++;
        $display("FAIL release_bounce step %0d: ready_in got %b want 1", i, bus.ready_in);
      end
    end
    vectors++;
    if (bus.in_port !== 8'h96) begin
      miscompares++;
      $display("FAIL release_bounce_port: got %h want 96", bus.in_port);
    end
    bus.btn_raw = 1'b0;
    repeat (7) step();
    vectors++;
    if (bus.ready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL release_after_bounce: ready_in got %b want 0", bus.ready_in);
    end
    repeat (2) step();
  endtask

  task automatic test_snapshot_hold();
    bus.sw_raw  = 8'h3C;
    bus.btn_raw = 1'b1;
    repeat (7) step();
    vectors++;
    if (bus.ready_in !== 1'b1 || bus.in_port !== 8'h3C) begin
      miscompares++;
      $display("FAIL snap_press: ready %b port %h want 1 3c", bus.ready_in, bus.in_port);
    end
    bus.sw_raw = 8'hFF;
    repeat (5) step();
    vectors++;
    if (bus.in_port !== 8'h3C) begin
      miscompares++;
      $display("FAIL snap_hold_pressed: got %h want 3c", bus.in_port);
    end
    bus.btn_raw = 1'b0;
    repeat (7) step();
    vectors++;
    if (bus.ready_in !== 1'b0 || bus.in_port !== 8'h3C) begin
      miscompares++;
      $display("FAIL snap_release: ready %b port %h want 0 3c", bus.ready_in, bus.in_port);
    end
    repeat (3) step();
    vectors++;
    if (bus.in_port !== 8'h3C) begin
      miscompares++;
      $display("FAIL snap_hold_released: got %h want 3c", bus.in_port);
    end
    bus.btn_raw = 1'b1;
    repeat (7) step();
    vectors++;
    if (bus.ready_in !== 1'b1 || bus.in_port !== 8'hFF) begin
      miscompares++;
      $display("FAIL snap_next_press: ready %b port %h want 1 ff", bus.ready_in, bus.in_port);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic exp;
    bus.btn_raw = 1'b0;
    repeat (7) step();
    bus.sw_raw  = 8'h5A;
    bus.btn_raw = 1'b1;
    repeat (4) step();
    vectors++;
    if (bus.ready_in !== 1'b0 || bus.in_port !== 8'hFF) begin
      miscompares++;
      $display("FAIL pre_reset: ready %b port %h want 0 ff", bus.ready_in, bus.in_port);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.ready_in !== 1'b0 || bus.in_port !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: ready %b port %h want 0 00", bus.ready_in, bus.in_port);
    end
    repeat (3) step();
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 7);
      vectors++;
      if (bus.ready_in !== exp) begin
        miscompares++;
        $display("FAIL post_reset_latency edge %0d: ready_in got %b want %b", i, bus.ready_in,
                 exp);
      end
    end
    vectors++;
    if (bus.in_port !== 8'h5A) begin
      miscompares++;
      $display("FAIL post_reset_snapshot: got %h want 5a", bus.in_port);
    end
  endtask

  task automatic test_integration();
    int loads0;
    int pc0;
    bus.btn_raw = 1'b0;
    repeat (9) step();
    loads0      = cpu_loads;
    pc0         = cpu_pc;
    bus.sw_raw  = 8'h77;
    bus.btn_raw = 1'b1;
    repeat (20) step();
    bus.btn_raw = 1'b0;
    repeat (10) step();
    vectors++;
    if (cpu_loads !== loads0 + 1) begin
      miscompares++;
      $display("FAIL cpu_loads: got %0d want %0d", cpu_loads - loads0, 1);
    end
    vectors++;
    if (cpu_pc !== pc0 + 1) begin
      miscompares++;
      $display("FAIL cpu_pc: advanced %0d want %0d", cpu_pc - pc0, 1);
    end
    vectors++;
    if (cpu_acc !== 8'h77) begin
      miscompares++;
      $display("FAIL cpu_acc: got %h want 77", cpu_acc);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.btn_raw = 1'b0;
    bus.sw_raw  = 8'h00;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_snapshot_hold();
    test_reset_mid_debounce();
    test_integration();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
